// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit: opcode constants, FSM states,
// default datapath width and small opcode classification helpers.
package alu_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b1010;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b1011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b0100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Opcodes handled by the multi-cycle shifter.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SRL) || (op == ALU_SLL);
    endfunction

    // Opcodes resolved combinationally in a single cycle.
    function automatic logic is_core_op(input logic [3:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND) ||
               (op == ALU_OR)  || (op == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response handshake bundle between a requester and the ALU unit.
interface alu_exec_unit_if #(
    parameter int unsigned WIDTH = alu_pkg::WIDTH_DEFAULT
) ();

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alucontrol;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    modport master (
        output in_valid, alucontrol, a, b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, alucontrol, a, b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );

endinterface

// File: rtl/alu_core.sv
// Combinational single-cycle ALU operations: add, sub, and, or, slt.
module alu_core import alu_pkg::*; #(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Select the arithmetic/logic result for the presented opcode.
    always_comb begin
        y = '0;
        case (alucontrol)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: accepts one request in IDLE, resolves single-cycle ops
// directly, runs shifts one bit per cycle, and holds the result in DONE until
// the consumer takes it.
module alu_exec_unit import alu_pkg::*; #(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input logic            clk,
    input logic            reset,
    alu_exec_unit_if.slave bus
);

    state_t           state, state_n;
    logic [WIDTH-1:0] result_q, result_n;
    logic [WIDTH-1:0] core_y;
    logic [4:0]       count_q, count_n;
    logic             shift_left_q, shift_left_n;
    logic             illegal_q, illegal_n;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .alucontrol (bus.alucontrol),
        .a          (bus.a),
        .b          (bus.b),
        .y          (core_y)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath registers: result, shift counter, shift direction, illegal flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q     <= '0;
            count_q      <= '0;
            shift_left_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            result_q     <= result_n;
            count_q      <= count_n;
            shift_left_q <= shift_left_n;
            illegal_q    <= illegal_n;
        end
    end

    // Next-state and next-datapath logic; inputs are only sampled on accept.
    always_comb begin
        state_n      = state;
        result_n     = result_q;
        count_n      = count_q;
        shift_left_n = shift_left_q;
        illegal_n    = illegal_q;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    illegal_n    = 1'b0;
                    shift_left_n = (bus.alucontrol == ALU_SLL);
                    if (is_shift_op(bus.alucontrol)) begin
                        result_n = bus.a;
                        if (bus.b[4:0] == 5'd0) begin
                            state_n = DONE;
                        end else begin
                            count_n = bus.b[4:0];
                            state_n = SHIFT;
                        end
                    end else if (is_core_op(bus.alucontrol)) begin
                        result_n = core_y;
                        state_n  = DONE;
                    end else begin
                        result_n  = '0;
                        illegal_n = 1'b1;
                        state_n   = DONE;
                    end
                end
            end
            SHIFT: begin
                result_n = shift_left_q ? (result_q << 1) : (result_q >> 1);
                count_n  = count_q - 5'd1;
                if (count_q == 5'd1) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = (result_q == '0);
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, handshake
// corner sequences and randomized operations against a behavioural model.
module tb_alu_exec_unit;

    logic clk = 1'b0;
    logic reset;

    int pass_cnt = 0;
    int total_cnt = 0;

    alu_exec_unit_if #(.WIDTH(32)) bus ();

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural reference: result, illegal flag and edges from accept to out_valid.
    function automatic void ref_model(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] res,
                                      output logic ill, output int lat);
        ill = 1'b0;
        lat = 1;
        case (op)
            4'b0010: res = a + b;
            4'b1010: res = a - b;
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b1011: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0111: begin res = a >> b[4:0]; lat = int'(b[4:0]) + 1; end
            4'b0100: begin res = a << b[4:0]; lat = int'(b[4:0]) + 1; end
            default: begin res = 32'd0; ill = 1'b1; end
        endcase
    endfunction

    // One full transaction; scrambles inputs while busy to prove they are ignored.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_ill, input int exp_lat,
                          input string tag);
        int lat;
        int guard;
        logic seen;
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.alucontrol = op;
        bus.a          = a;
        bus.b          = b;
        bus.out_ready  = 1'($urandom_range(0, 1));
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        lat = 1;
        seen = 1'b0;
        guard = 0;
        while (!seen && guard < 40) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
            end else begin
                bus.in_valid   = 1'($urandom_range(0, 1));
                bus.alucontrol = 4'($urandom);
                bus.a          = $urandom;
                bus.b          = $urandom;
                bus.out_ready  = 1'($urandom_range(0, 1));
                @(posedge clk);
                lat++;
                guard++;
            end
        end
        check({tag, " completed"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, bus.result, exp_res);
        check({tag, " zero"}, 32'(bus.zero), 32'(exp_res == 32'd0));
        check({tag, " illegal"}, 32'(bus.illegal), 32'(exp_ill));
        check({tag, " busy in_ready"}, 32'(bus.in_ready), 32'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, " drained"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] exp_res;
        logic        exp_ill;
        int          exp_lat;
        logic [31:0] ra, rb;
        logic [3:0]  rop;
        logic [3:0]  legal_ops[7];
        int          seen_valid;

        vecs[0]  = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1};
        vecs[1]  = '{4'b1010, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1};
        vecs[2]  = '{4'b1011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1};
        vecs[3]  = '{4'b0111, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 32};
        vecs[4]  = '{4'b0100, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b0, 1};
        vecs[5]  = '{4'b1111, 32'hDEAD_BEEF, 32'h0000_0003, 32'h0000_0000, 1'b1, 1};
        vecs[6]  = '{4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1};
        vecs[7]  = '{4'b0001, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b0, 1};
        vecs[8]  = '{4'b0100, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32};
        vecs[9]  = '{4'b1011, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1};
        vecs[10] = '{4'b0111, 32'hF000_0000, 32'h0000_0024, 32'h0F00_0000, 1'b0, 5};

        legal_ops = '{4'b0010, 4'b1010, 4'b0000, 4'b0001, 4'b1011, 4'b0111, 4'b0100};

        bus.in_valid   = 1'b0;
        bus.alucontrol = 4'b0000;
        bus.a          = 32'd0;
        bus.b          = 32'd0;
        bus.out_ready  = 1'b0;
        reset          = 1'b1;

        #1;
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset result", bus.result, 32'd0);
        check("reset zero", 32'(bus.zero), 32'd1);
        check("reset illegal", 32'(bus.illegal), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ill,
                   vecs[i].lat, $sformatf("vec%0d", i));
        end

        // Illegal op held in DONE with out_ready low; new requests must be refused.
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.alucontrol = 4'b1111;
        bus.a          = 32'h1111_1111;
        bus.b          = 32'h2222_2222;
        bus.out_ready  = 1'b0;
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("hold%0d out_valid", c), 32'(bus.out_valid), 32'd1);
            check($sformatf("hold%0d result", c), bus.result, 32'd0);
            check($sformatf("hold%0d illegal", c), 32'(bus.illegal), 32'd1);
            check($sformatf("hold%0d zero", c), 32'(bus.zero), 32'd1);
            check($sformatf("hold%0d in_ready", c), 32'(bus.in_ready), 32'd0);
            bus.in_valid   = 1'b1;
            bus.alucontrol = 4'b0010;
            bus.a          = $urandom;
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("hold drained in_ready", 32'(bus.in_ready), 32'd1);

        // Reset pulsed mid-shift discards the operation.
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.alucontrol = 4'b0100;
        bus.a          = 32'h0000_0ABC;
        bus.b          = 32'd20;
        @(posedge clk);
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset in_ready", 32'(bus.in_ready), 32'd1);
        check("midreset out_valid", 32'(bus.out_valid), 32'd0);
        check("midreset result", bus.result, 32'd0);
        check("midreset zero", 32'(bus.zero), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        seen_valid = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen_valid++;
        end
        check("midreset no output", 32'(seen_valid), 32'd0);
        run_op(4'b0010, 32'd3, 32'd4, 32'd7, 1'b0, 1, "post_reset add");

        // Back-to-back adds with in_valid and out_ready held high.
        exp_res = 32'd0;
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.out_ready  = 1'b1;
        bus.alucontrol = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("b2b%0d in_ready", i), 32'(bus.in_ready), 32'((i % 2) == 0));
            if ((i % 2) == 1) begin
                check($sformatf("b2b%0d out_valid", i), 32'(bus.out_valid), 32'd1);
                check($sformatf("b2b%0d result", i), bus.result, exp_res);
            end
            bus.a = $urandom;
            bus.b = $urandom;
            if ((i % 2) == 0) exp_res = bus.a + bus.b;
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Randomized operations against the reference model.
        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 9) == 0) rop = 4'($urandom);
            else rop = legal_ops[$urandom_range(0, 6)];
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            ref_model(rop, ra, rb, exp_res, exp_ill, exp_lat);
            run_op(rop, ra, rb, exp_res, exp_ill, exp_lat, $sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
